pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//   Controller on the far end of the PLL rst/locked interface: drives the PLL reset, qualifies its
//   locked output and generates the downstream system reset. Runs on the free-running PLL
//   reference clock. Retries on lock timeout, declares failure after MAX_RETRIES timeouts, and
//   re-sequences the PLL on loss of lock.
// PARAMETERS
//   RST_HOLD_CYCLES     16      cycles pll_rst is held high per reset attempt (>=1)
//   LOCK_TIMEOUT_CYCLES 100000  cycles allowed in WAIT_LOCK before a retry (>=1)
//   LOCK_STABLE_CYCLES  1024    consecutive synced-locked cycles required before release (>=1)
//   MAX_RETRIES         4       lock timeouts tolerated; the MAX_RETRIES-th timeout enters FAILED (>=1)
//   SYNC_STAGES         2       flops in the pll_locked synchronizer (>=2)
// PORTS
//   refclk        in   1   supervisor clock; free-running, independent of PLL lock
//   rst_n         in   1   asynchronous, active-low reset
//   pll_locked    in   1   PLL lock indication; asynchronous to refclk
//   retry_req     in   1   single-cycle pulse; restarts sequencing from FAILED, ignored elsewhere
//   pll_rst       out  1   active-high reset to the PLL
//   sys_rst_n     out  1   active-low reset to logic clocked by the PLL outputs
//   ready         out  1   high only in RUN
//   fail          out  1   high only in FAILED
//   retry_count   out  $clog2(MAX_RETRIES+1)  timeouts since the last RUN entry or retry_req
//   loss_count    out  8   lock losses seen in RUN; saturates at 255; cleared only by rst_n
// BEHAVIOUR
//   - Reset (rst_n=0, no clock required): state=RESET_PLL, cnt=0, sync chain=0, pll_rst=1,
//     sys_rst_n=0, ready=0, fail=0, retry_count=0, loss_count=0.
//   - locked_s = pll_locked after SYNC_STAGES flops. The FSM uses only locked_s.
//   - All outputs are registered and update on the same edge as the state change
//     (Moore, no combinational paths from inputs).
//   - One counter, cnt, is cleared on every state transition.
//   - RESET_PLL: pll_rst=1. On cnt==RST_HOLD_CYCLES-1, go to WAIT_LOCK; else cnt++.
//   - WAIT_LOCK: pll_rst=0.
//       - locked_s=1: go to STABLE.
//       - Else, on cnt==LOCK_TIMEOUT_CYCLES-1: retry_count++; if the new value == MAX_RETRIES,
//         go to FAILED, otherwise go to RESET_PLL.
//       - Else cnt++.
//   - STABLE: pll_rst=0.
//       - locked_s=0: go to WAIT_LOCK. The timeout restarts from 0; retry_count is unchanged.
//       - Else, on cnt==LOCK_STABLE_CYCLES-1: go to RUN and clear retry_count.
//       - Else cnt++.
//   - RUN: sys_rst_n=1, ready=1. On locked_s=0: go to RESET_PLL with sys_rst_n=0 and ready=0
//     on that edge; loss_count increments and saturates at 255.
//   - FAILED: pll_rst=1, fail=1, sys_rst_n=0. On retry_req=1: go to RESET_PLL, retry_count=0,
//     fail=0.
//   - sys_rst_n is 0 in every state except RUN. pll_rst is 1 only in RESET_PLL and FAILED.
//   - Latency: pll_locked rise to sys_rst_n rise = SYNC_STAGES+1+LOCK_STABLE_CYCLES edges.
//     pll_locked fall in RUN to sys_rst_n fall = SYNC_STAGES+1 edges.
//   - retry_req in any state other than FAILED has no effect.
//   - rst_n assertion in any state returns every output to its reset value immediately.
// TESTING (RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=3, SYNC=2)
//   1. Release rst_n with pll_locked=0: pll_rst stays 1 for 4 edges then falls. Raise pll_locked
//      5 cycles later: sys_rst_n=1 and ready=1 exactly 11 edges after the pll_locked rise;
//      retry_count=0.
//   2. In STABLE, drop pll_locked for 1 cycle after 5 stable cycles: sys_rst_n stays 0. Release
//      occurs 11 edges after the re-rise; retry_count is unchanged.
//   3. Hold pll_locked=0: pll_rst re-pulses after each 20-cycle wait and retry_count goes 1, 2.
//      On the 3rd timeout fail=1, retry_count=3, pll_rst=1 held. retry_req=1 for 1 cycle gives
//      fail=0, retry_count=0, pll_rst=1 for 4 cycles.
//   4. In RUN, drop pll_locked: sys_rst_n=0 and ready=0 3 edges later, loss_count 0->1, pll_rst=1
//      for 4 cycles, then reacquire. Force 300 losses: loss_count reads 255.
//   5. Assert rst_n mid-WAIT_LOCK (cnt=10, no clock edge): all outputs at reset values at once.
//      Pulse retry_req in RUN: no state or output change.

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and the PLL / downstream reset domain.
// The master side is the supervisor; the slave side is the PLL plus its consumers.
interface pll_lock_supervisor_if #(
    parameter int MAX_RETRIES = 4
) ();
    localparam int RC_W = $clog2(MAX_RETRIES + 1);

    logic            pll_locked;
    logic            retry_req;
    logic            pll_rst;
    logic            sys_rst_n;
    logic            ready;
    logic            fail;
    logic [RC_W-1:0] retry_count;
    logic [7:0]      loss_count;

    modport master (
        input  pll_locked,
        input  retry_req,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fail,
        output retry_count,
        output loss_count
    );

    modport slave (
        output pll_locked,
        output retry_req,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fail,
        input  retry_count,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies the synchronized lock indication and generates the
// downstream system reset, with bounded retries and re-sequencing on loss of lock.
module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 4,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.master bus
);
    localparam int RC_W    = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES)
                           ? ((RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES)
                           : ((LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAILED    = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   pll_rst_q;
    logic                   sys_rst_n_q;
    logic                   ready_q;
    logic                   fail_q;
    logic [RC_W-1:0]        retry_count_q;
    logic [RC_W-1:0]        retry_count_inc;
    logic [7:0]             loss_count_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Lock synchronizer: pll_locked is asynchronous to refclk
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end

    assign locked_s        = sync_q[SYNC_STAGES-1];
    assign retry_count_inc = retry_count_q + RC_W'(1);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET_PLL;
            cnt           <= '0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            retry_count_q <= '0;
            loss_count_q  <= '0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == HOLD_LAST) begin
                        state     <= S_WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt           <= '0;
                        retry_count_q <= retry_count_inc;
                        pll_rst_q     <= 1'b1;
                        if (retry_count_inc == RETRY_LIMIT) begin
                            state  <= S_FAILED;
                            fail_q <= 1'b1;
                        end else begin
                            state <= S_RESET_PLL;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    // A lock glitch restarts the timeout but does not count as a retry
                    if (!locked_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state         <= S_RUN;
                        cnt           <= '0;
                        retry_count_q <= '0;
                        sys_rst_n_q   <= 1'b1;
                        ready_q       <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state        <= S_RESET_PLL;
                        cnt          <= '0;
                        pll_rst_q    <= 1'b1;
                        sys_rst_n_q  <= 1'b0;
                        ready_q      <= 1'b0;
                        loss_count_q <= sat_inc8(loss_count_q);
                    end
                end
                S_FAILED: begin
                    if (bus.retry_req) begin
                        state         <= S_RESET_PLL;
                        cnt           <= '0;
                        retry_count_q <= '0;
                        fail_q        <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_RESET_PLL;
                    cnt         <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_count_q;
    assign bus.loss_count  = loss_count_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: stimulus queues expected output values and a
// negedge monitor pops and compares them against the DUT.
module tb_pll_lock_supervisor;
    localparam int SEL_PLL_RST = 0;
    localparam int SEL_SYS_RST = 1;
    localparam int SEL_READY   = 2;
    localparam int SEL_FAIL    = 3;
    localparam int SEL_RC      = 4;
    localparam int SEL_LC      = 5;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } exp_t;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    pll_lock_supervisor_if #(.MAX_RETRIES(3)) bus ();

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (3),
        .SYNC_STAGES        (2)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    function automatic int sample(input int sel);
        case (sel)
            SEL_PLL_RST: return int'(bus.pll_rst);
            SEL_SYS_RST: return int'(bus.sys_rst_n);
            SEL_READY:   return int'(bus.ready);
            SEL_FAIL:    return int'(bus.fail);
            SEL_RC:      return int'(bus.retry_count);
            default:     return int'(bus.loss_count);
        endcase
    endfunction

    always @(negedge refclk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            int   act;
            e   = sb_q.pop_front();
            act = sample(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d at %0t", e.name, act, e.exp, $time);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input int exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic expect_reset_values(input string tag);
        expect_val({tag, "_pll_rst"},   SEL_PLL_RST, 1);
        expect_val({tag, "_sys_rst_n"}, SEL_SYS_RST, 0);
        expect_val({tag, "_ready"},     SEL_READY,   0);
        expect_val({tag, "_fail"},      SEL_FAIL,    0);
        expect_val({tag, "_retry_cnt"}, SEL_RC,      0);
        expect_val({tag, "_loss_cnt"},  SEL_LC,      0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 64 && !bus.ready; i++) tick(1);
        checks++;
        if (!bus.ready) begin
            errors++;
            $display("FAIL %s: ready still %0b after 64 cycles, expected 1", name, bus.ready);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.retry_req  = 1'b0;
        tick(2);
        expect_reset_values("reset");

        // Test 1: initial acquisition
        tick(1);
        rst_n = 1'b1;
        tick(3);
        expect_val("t1_pll_rst_held", SEL_PLL_RST, 1);
        tick(1);
        expect_val("t1_pll_rst_fall", SEL_PLL_RST, 0);
        tick(5);
        bus.pll_locked = 1'b1;
        tick(10);
        expect_val("t1_sys_rst_edge10", SEL_SYS_RST, 0);
        expect_val("t1_ready_edge10",   SEL_READY,   0);
        tick(1);
        expect_val("t1_sys_rst_edge11", SEL_SYS_RST, 1);
        expect_val("t1_ready_edge11",   SEL_READY,   1);
        expect_val("t1_retry_cnt",      SEL_RC,      0);

        // Test 4a: loss of lock in RUN
        tick(2);
        bus.pll_locked = 1'b0;
        tick(2);
        expect_val("t4_sys_rst_edge2", SEL_SYS_RST, 1);
        expect_val("t4_loss_edge2",    SEL_LC,      0);
        tick(1);
        expect_val("t4_sys_rst_edge3", SEL_SYS_RST, 0);
        expect_val("t4_ready_edge3",   SEL_READY,   0);
        expect_val("t4_loss_edge3",    SEL_LC,      1);
        expect_val("t4_pll_rst_edge3", SEL_PLL_RST, 1);
        tick(3);
        expect_val("t4_pll_rst_hold", SEL_PLL_RST, 1);
        tick(1);
        expect_val("t4_pll_rst_fall", SEL_PLL_RST, 0);

        // Test 2: one-cycle lock glitch while STABLE
        bus.pll_locked = 1'b1;
        tick(8);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(5);
        expect_val("t2_sys_rst_mid", SEL_SYS_RST, 0);
        tick(5);
        expect_val("t2_sys_rst_edge10", SEL_SYS_RST, 0);
        expect_val("t2_retry_cnt",      SEL_RC,      0);
        tick(1);
        expect_val("t2_sys_rst_edge11", SEL_SYS_RST, 1);
        expect_val("t2_ready_edge11",   SEL_READY,   1);

        // Test 4b: saturate the loss counter
        for (int k = 0; k < 299; k++) begin
            bus.pll_locked = 1'b0;
            tick(3);
            bus.pll_locked = 1'b1;
            wait_ready("t4_reacquire");
        end
        tick(1);
        expect_val("t4_loss_sat", SEL_LC, 255);

        // Test 3: repeated lock timeouts to FAILED, then retry_req
        tick(1);
        bus.pll_locked = 1'b0;
        tick(3);
        expect_val("t3_loss_still_sat", SEL_LC,      255);
        expect_val("t3_pll_rst_start",  SEL_PLL_RST, 1);
        tick(4);
        expect_val("t3_wait1_pll_rst", SEL_PLL_RST, 0);
        tick(19);
        expect_val("t3_wait1_end_pll_rst", SEL_PLL_RST, 0);
        expect_val("t3_wait1_end_rc",      SEL_RC,      0);
        tick(1);
        expect_val("t3_timeout1_pll_rst", SEL_PLL_RST, 1);
        expect_val("t3_timeout1_rc",      SEL_RC,      1);
        tick(24);
        expect_val("t3_timeout2_pll_rst", SEL_PLL_RST, 1);
        expect_val("t3_timeout2_rc",      SEL_RC,      2);
        expect_val("t3_timeout2_fail",    SEL_FAIL,    0);
        tick(24);
        expect_val("t3_failed_fail",    SEL_FAIL,    1);
        expect_val("t3_failed_rc",      SEL_RC,      3);
        expect_val("t3_failed_pll_rst", SEL_PLL_RST, 1);
        tick(10);
        expect_val("t3_failed_hold_fail",    SEL_FAIL,    1);
        expect_val("t3_failed_hold_pll_rst", SEL_PLL_RST, 1);
        expect_val("t3_failed_sys_rst",      SEL_SYS_RST, 0);
        bus.retry_req = 1'b1;
        tick(1);
        bus.retry_req = 1'b0;
        expect_val("t3_retry_fail",    SEL_FAIL,    0);
        expect_val("t3_retry_rc",      SEL_RC,      0);
        expect_val("t3_retry_pll_rst", SEL_PLL_RST, 1);
        tick(3);
        expect_val("t3_retry_pll_rst_hold", SEL_PLL_RST, 1);
        tick(1);
        expect_val("t3_retry_pll_rst_fall", SEL_PLL_RST, 0);

        // Test 5: asynchronous reset mid-WAIT_LOCK, then retry_req ignored in RUN
        tick(10);
        rst_n = 1'b0;
        expect_reset_values("t5_async");
        tick(2);
        rst_n = 1'b1;
        bus.pll_locked = 1'b1;
        wait_ready("t5_reacquire");
        tick(1);
        bus.retry_req = 1'b1;
        tick(1);
        bus.retry_req = 1'b0;
        expect_val("t5_run_ready",   SEL_READY,   1);
        expect_val("t5_run_sys_rst", SEL_SYS_RST, 1);
        expect_val("t5_run_pll_rst", SEL_PLL_RST, 0);
        expect_val("t5_run_fail",    SEL_FAIL,    0);
        expect_val("t5_run_rc",      SEL_RC,      0);
        expect_val("t5_run_lc",      SEL_LC,      0);
        tick(5);
        expect_val("t5_run_ready_later", SEL_READY, 1);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
